// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package mc_ctrl_pkg;

    // Controller states; the numeric values are visible on the State debug port.
    typedef enum logic [3:0] {
        StFetch    = 4'h0,
        StDecode   = 4'h1,
        StMemAdr   = 4'h2,
        StMemRead  = 4'h3,
        StMemWb    = 4'h4,
        StMemWrite = 4'h5,
        StExecuteR = 4'h6,
        StExecuteI = 4'h7,
        StAluWb    = 4'h8,
        StJal      = 4'h9,
        StIllegal  = 4'hA,
        StBeq      = 4'hB
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [1:0] AluOpAdd  = 2'b00;
    localparam logic [1:0] AluOpSub  = 2'b01;
    localparam logic [1:0] AluOpFunc = 2'b10;

    localparam logic [3:0] AluAdd  = 4'h0;
    localparam logic [3:0] AluSub  = 4'h1;
    localparam logic [3:0] AluAnd  = 4'h2;
    localparam logic [3:0] AluOr   = 4'h3;
    localparam logic [3:0] AluXor  = 4'h4;
    localparam logic [3:0] AluSlt  = 4'h5;
    localparam logic [3:0] AluSltu = 4'h6;
    localparam logic [3:0] AluSll  = 4'h7;
    localparam logic [3:0] AluSrl  = 4'h8;
    localparam logic [3:0] AluSra  = 4'h9;

    // Immediate format selected purely from the opcode field.
    function automatic logic [1:0] imm_src_of(logic [6:0] opcode);
        logic [1:0] imm;
        imm = ImmI;
        case (opcode)
            OpStore:  imm = ImmS;
            OpBranch: imm = ImmB;
            OpJal:    imm = ImmJ;
            default:  imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath signal bundle.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [3:0] ALUCtl;
    logic       IllegalInstr;
    logic [3:0] State;

    // Controller side.
    modport master (
        input  opcode, func3, func7_5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUCtl, IllegalInstr, State
    );

    // Datapath side.
    modport slave (
        output opcode, func3, func7_5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUCtl, IllegalInstr, State
    );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields to an ALU operation.
module multicycle_control_fsm_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] func3_i,
    input  logic       func7_5_i,
    input  logic       opcode_5_i,
    output logic [3:0] alu_ctl_o
);

    // Only R-type (opcode[5]=1) may select SUB; for addi bit 30 is immediate data.
    always_comb begin
        alu_ctl_o = AluAdd;
        case (alu_op_i)
            AluOpAdd: alu_ctl_o = AluAdd;
            AluOpSub: alu_ctl_o = AluSub;
            AluOpFunc: begin
                case (func3_i)
                    3'b000:  alu_ctl_o = (opcode_5_i && func7_5_i) ? AluSub : AluAdd;
                    3'b001:  alu_ctl_o = AluSll;
                    3'b010:  alu_ctl_o = AluSlt;
                    3'b011:  alu_ctl_o = AluSltu;
                    3'b100:  alu_ctl_o = AluXor;
                    3'b101:  alu_ctl_o = func7_5_i ? AluSra : AluSrl;
                    3'b110:  alu_ctl_o = AluOr;
                    default: alu_ctl_o = AluAnd;
                endcase
            end
            default: alu_ctl_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/writeback sequencing.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter bit MEM_WAIT_EN  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_fsm_if.master  bus
);

    state_e     state_q, state_d;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       pc_write, ir_write, mem_write, reg_write, illegal;
    logic       adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b;

    assign mem_ready = MEM_WAIT_EN ? bus.MemReady : 1'b1;

    // State register, asynchronously returned to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        adr_src    = 1'b0;
        result_src = ResAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluOpAdd;
        case (state_q)
            StFetch: begin
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Branch/jump target is precomputed into ALUOut here.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecuteR;
                    OpItype:         state_d = StExecuteI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = (bus.func3[2:1] == 2'b00) ? StBeq : StIllegal;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                // opcode[5] separates store (1) from load (0).
                state_d   = bus.opcode[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExecuteR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluOpFunc;
                state_d   = StAluWb;
            end
            StExecuteI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluOpFunc;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // PC <= target held in ALUOut; ALU forms OldPC+4 for the link.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StBeq: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluOpSub;
                // func3[0] inverts the sense: beq takes on Zero, bne on !Zero.
                pc_write  = bus.Zero ^ bus.func3[0];
                state_d   = StFetch;
            end
            StIllegal: begin
                illegal = 1'b1;
                if (!ILLEGAL_HALT) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    multicycle_control_fsm_alu_decoder u_alu_decoder (
        .alu_op_i   (alu_op),
        .func3_i    (bus.func3),
        .func7_5_i  (bus.func7_5),
        .opcode_5_i (bus.opcode[5]),
        .alu_ctl_o  (bus.ALUCtl)
    );

    // Strobes are forced low for as long as reset is held, independent of state.
    assign bus.PCWrite      = pc_write & rst_n;
    assign bus.IRWrite      = ir_write & rst_n;
    assign bus.MemWrite     = mem_write & rst_n;
    assign bus.RegWrite     = reg_write & rst_n;
    assign bus.IllegalInstr = illegal & rst_n;
    assign bus.AdrSrc       = adr_src;
    assign bus.ResultSrc    = result_src;
    assign bus.ALUSrcA      = alu_src_a;
    assign bus.ALUSrcB      = alu_src_b;
    assign bus.ImmSrc       = imm_src_of(bus.opcode);
    assign bus.State        = state_q;

endmodule
